// File: rtl/risc_decode_pipe.sv
// Opcode decoder with a single output register stage and multi-cycle expansion of class 3'b111.
// Optional feature: define RISC_DECODE_NOP_DROP_EN to swallow all-zero opcodes without emitting a beat.
module risc_decode_pipe #(
  parameter int OPC_W    = 8,
  parameter int MC_STEPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_class,
  output logic [OPC_W-4:0] out_sub,
  output logic [3:0]       out_step,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic {IDLE, EXPAND} state_e;

  localparam logic [3:0] LAST_STEP = 4'(MC_STEPS - 1);
  localparam bit         MULTI     = (MC_STEPS > 1);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_class_q, out_class_d;
  logic [OPC_W-4:0] out_sub_q, out_sub_d;
  logic [3:0]       out_step_q, out_step_d;
  logic             out_last_q, out_last_d;
  logic [15:0]      op_count_q, op_count_d;

  logic [2:0] opc_class;
  logic       accept;
  logic       consume;
  logic       drop_nop;
  logic       is_mc;
  logic [3:0] step_inc;

  assign opc_class = in_opc[OPC_W-1:OPC_W-3];
  assign is_mc     = (opc_class == 3'b111) && MULTI;
  assign step_inc  = out_step_q + 4'd1;

`ifdef RISC_DECODE_NOP_DROP_EN
  assign drop_nop = (in_opc == '0);
`else
  assign drop_nop = 1'b0;
`endif

  // Reset gates in_ready so opcodes offered during reset are neither consumed nor counted.
  assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  // NOTE: every always_comb output is given its hold value first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_sub_d   = out_sub_q;
    out_step_d  = out_step_q;
    out_last_d  = out_last_q;
    op_count_d  = op_count_q;

    if (consume) begin
      out_valid_d = 1'b0;
      if (state_q == EXPAND) begin
        out_valid_d = 1'b1;
        out_step_d  = step_inc;
        if (step_inc == LAST_STEP) begin
          out_last_d = 1'b1;
          state_d    = IDLE;
        end
      end
    end

    // Accept only happens in IDLE, so it never collides with the EXPAND reload above.
    if (accept) begin
      op_count_d = op_count_q + 16'd1;
      if (!drop_nop) begin
        out_valid_d = 1'b1;
        out_class_d = 8'b1 << opc_class;
        out_sub_d   = in_opc[OPC_W-4:0];
        out_step_d  = 4'd0;
        out_last_d  = !is_mc;
        state_d     = is_mc ? EXPAND : IDLE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_sub_q   <= '0;
      out_step_q  <= '0;
      out_last_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_sub_q   <= out_sub_d;
      out_step_q  <= out_step_d;
      out_last_q  <= out_last_d;
      op_count_q  <= op_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_sub   = out_sub_q;
  assign out_step  = out_step_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == EXPAND);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_risc_decode_pipe.sv
// Directed, table-driven bench for risc_decode_pipe (OPC_W=8, MC_STEPS=4).
module tb_risc_decode_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_opc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_class;
  logic [4:0] out_sub;
  logic [3:0] out_step;
  logic       out_last;
  logic       busy;
  logic [15:0] op_count;

  risc_decode_pipe #(.OPC_W(8), .MC_STEPS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_sub(out_sub), .out_step(out_step),
    .out_last(out_last), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] opc;
    logic       exp_valid;
    logic [7:0] exp_class;
    logic [4:0] exp_sub;
    logic       exp_last;
  } vec_t;

  vec_t        vecs[6];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'h45, 1'b1, 8'h04, 5'h05, 1'b1};
    vecs[1] = '{8'h21, 1'b1, 8'h02, 5'h01, 1'b1};
    vecs[2] = '{8'h42, 1'b1, 8'h04, 5'h02, 1'b1};
    vecs[3] = '{8'h1F, 1'b1, 8'h01, 5'h1F, 1'b1};
    vecs[4] = '{8'hDF, 1'b1, 8'h40, 5'h1F, 1'b1};
`ifdef RISC_DECODE_NOP_DROP_EN
    vecs[5] = '{8'h00, 1'b0, 8'h00, 5'h00, 1'b0};
`else
    vecs[5] = '{8'h00, 1'b1, 8'h01, 5'h00, 1'b1};
`endif

    // Reset with an opcode offered; it must be ignored.
    rst = 1'b1; in_valid = 1'b1; in_opc = 8'h45; out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_class", 32'(out_class), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    exp_cnt = 16'd0;

    // Single-beat opcodes back to back: each beat appears the next cycle, no bubbles.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_opc = vecs[i].opc; out_ready = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      exp_cnt = exp_cnt + 16'd1;
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_class", i), 32'(out_class), 32'(vecs[i].exp_class));
        check($sformatf("v%0d_sub", i), 32'(out_sub), 32'(vecs[i].exp_sub));
        check($sformatf("v%0d_step", i), 32'(out_step), 32'd0);
        check($sformatf("v%0d_last", i), 32'(out_last), 32'(vecs[i].exp_last));
      end
      check($sformatf("v%0d_op_count", i), 32'(op_count), 32'(exp_cnt));
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: beat held for 5 cycles, second opcode not taken.
    in_valid = 1'b1; in_opc = 8'h45; out_ready = 1'b0;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    in_opc = 8'h21;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_class", i), 32'(out_class), 32'h04);
      check($sformatf("bp%0d_sub", i), 32'(out_sub), 32'h05);
      tick();
    end
    check("bp_op_count", 32'(op_count), 32'(exp_cnt));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);

    // Multi-cycle expansion of 0xE3.
    in_valid = 1'b1; in_opc = 8'hE3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("mc%0d_valid", s), 32'(out_valid), 32'd1);
      check($sformatf("mc%0d_class", s), 32'(out_class), 32'h80);
      check($sformatf("mc%0d_sub", s), 32'(out_sub), 32'h03);
      check($sformatf("mc%0d_step", s), 32'(out_step), 32'(s));
      check($sformatf("mc%0d_last", s), 32'(out_last), 32'(s == 3));
      check($sformatf("mc%0d_busy", s), 32'(busy), 32'(s != 3));
      check($sformatf("mc%0d_in_ready", s), 32'(in_ready), 32'(s == 3));
      tick();
    end
    check("mc_done_valid", 32'(out_valid), 32'd0);
    check("mc_op_count", 32'(op_count), 32'(exp_cnt));

    // Reset during step 1 abandons the expansion.
    in_valid = 1'b1; in_opc = 8'hE3;
    tick();
    in_valid = 1'b0;
    tick();
    check("rst_mid_step", 32'(out_step), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_op_count", 32'(op_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_mid_quiet%0d", i), 32'(out_valid), 32'd0);
    end

    // Counter wrap after 65536 accepts.
    in_valid = 1'b1; in_opc = 8'h21; out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk);
    end
    #1;
    check("cnt_ffff", 32'(op_count), 32'hFFFF);
    tick();
    check("cnt_wrap", 32'(op_count), 32'h0);
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/risc_decode_pipe.md
RISC_DECODE_PIPE -- requirements
Module: risc_decode_pipe

Interface
REQ-001 SHALL have parameter OPC_W, default 8, meaning opcode width (min 4).
REQ-002 SHALL have parameter MC_STEPS, default 4, meaning micro-op count for multi-cycle class 3'b111 (min 1, max 16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  opcode offered.
REQ-006 SHALL have port in_ready  output  1  opcode accepted this cycle when high with in_valid.
REQ-007 SHALL have port in_opc  input  OPC_W  opcode; class = in_opc[OPC_W-1:OPC_W-3], sub = remaining low bits.
REQ-008 SHALL have port out_valid  output  1  control beat present.
REQ-009 SHALL have port out_ready  input  1  downstream consumes beat.
REQ-010 SHALL have port out_class  output  8  one-hot decoded class.
REQ-011 SHALL have port out_sub  output  OPC_W-3  sub field passthrough.
REQ-012 SHALL have port out_step  output  4  micro-op index.
REQ-013 SHALL have port out_last  output  1  final beat of current instruction.
REQ-014 SHALL have port busy  output  1  high while in EXPAND state.
REQ-015 SHALL have port op_count  output  16  accepted-instruction counter.

Function
REQ-016 SHALL use a single output register stage; latency in_opc accept to out_valid = 1 cycle.
REQ-017 SHALL decode out_class = 1 << class; out_sub = sub, unmodified.
REQ-018 SHALL have states IDLE and EXPAND; busy = (state==EXPAND).
REQ-019 in_ready SHALL = (state==IDLE) & (~out_valid | out_ready), combinational.
REQ-020 On accept of class != 3'b111, or of class 3'b111 with MC_STEPS==1, SHALL load the beat with out_step=0, out_last=1, and remain IDLE.
REQ-021 On accept of class 3'b111 with MC_STEPS>1, SHALL load the beat with out_step=0, out_last=0, and enter EXPAND.
REQ-022 In EXPAND, on out_valid&out_ready, SHALL reload the beat with out_step+1, same class/sub; out_last=1 and transition to IDLE when out_step+1 == MC_STEPS-1.
REQ-023 Output beat contents SHALL hold stable while out_valid & ~out_ready.
REQ-024 SHALL clear out_valid on out_valid&out_ready when nothing new is loaded in that cycle.
REQ-025 Simultaneous consume of a last beat and accept of a new opcode SHALL load the new beat in the same cycle, with no bubble.
REQ-026 op_count SHALL increment by 1 per accepted opcode (not per micro-op), wrapping 0xFFFF -> 0x0000.

Reset
REQ-027 On rst high at a clock edge, SHALL set state=IDLE, out_valid=0, out_class=0, out_sub=0, out_step=0, out_last=0, op_count=0, regardless of the operation in flight.
REQ-028 in_ready SHALL be 0 during the rst cycle; any in_valid during rst SHALL be ignored.
REQ-029 A multi-cycle expansion interrupted by rst SHALL be abandoned; no remaining micro-ops are emitted after reset.

Configuration
REQ-030 Macro RISC_DECODE_NOP_DROP_EN: when defined, an accepted opcode of all zeros SHALL be consumed and counted in op_count, but no beat SHALL be loaded. When undefined, an all-zero opcode SHALL be emitted as class 0 (out_class=0x01, out_last=1).

Verification (OPC_W=8, MC_STEPS=4)
REQ-031 Scenario 1: reset, then in_opc=0x45 with out_ready=1 -> next cycle out_class=0x04, out_sub=0x05, out_step=0, out_last=1, and op_count=1.
REQ-032 Scenario 2: in_opc=0xE3 with out_ready=1 -> four consecutive beats, out_class=0x80, out_sub=0x03, out_step 0,1,2,3, out_last only on step 3; in_ready=0 and busy=1 until step 3 is loaded.
REQ-033 Scenario 3: out_ready=0 for 5 cycles after 0x45 is loaded -> beat held unchanged, in_ready=0, and a second in_valid is not accepted.
REQ-034 Scenario 4: back-to-back 0x21, 0x42 with out_ready=1 -> beats on consecutive cycles with no bubble.
REQ-035 Scenario 5: rst asserted during step 1 of 0xE3 -> next cycle out_valid=0, busy=0, op_count=0; no steps 2 or 3 appear.
REQ-036 Scenario 6: 65536 accepted opcodes -> op_count wraps to 0; opcode 0x00 -> beat emitted (class 0x01) without the macro, no beat with the macro, and op_count increments in both builds.
